// File: rtl/riscv_trace_buffer.sv
// Timestamped tracer for RISC-V register-writeback and data-memory side-band traffic.
// Records are queued in a DEPTH-entry FIFO and drained through a valid/ready port.
module riscv_trace_buffer #(
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 9,
    parameter int TS_W    = 16,
    parameter int SKIP_X0 = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_reg_en,
    input  logic                       cfg_mem_en,
    input  logic                       RegWriteSignal,
    input  logic [4:0]                 RegNum,
    input  logic [31:0]                RegData,
    input  logic                       WriteEnable,
    input  logic                       ReadEnable,
    input  logic [ADDR_W-1:0]          Address,
    input  logic [31:0]                WRData,
    input  logic [31:0]                RDData,
    output logic                       trace_valid,
    input  logic                       trace_ready,
    output logic [2:0]                 trace_kind,
    output logic [4:0]                 trace_reg_num,
    output logic [31:0]                trace_reg_data,
    output logic [ADDR_W-1:0]          trace_mem_addr,
    output logic [31:0]                trace_mem_data,
    output logic [TS_W-1:0]            trace_ts,
    output logic [$clog2(DEPTH):0]     level,
    output logic [15:0]                drop_count,
    output logic                       conflict
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int REC_W = 3 + 5 + 32 + ADDR_W + 32 + TS_W;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    logic [TS_W-1:0]  r_ts;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic [15:0]      r_drop;
    logic             r_conflict;
    logic [REC_W-1:0] r_mem [DEPTH];

    logic             w_x0;
    logic             w_reg_hit;
    logic             w_wr_hit;
    logic             w_rd_hit;
    logic             w_mem_hit;
    logic             w_push;
    logic             w_pop;
    logic             w_accept;
    logic [REC_W-1:0] w_rec;
    logic [REC_W-1:0] w_head;

    assign w_x0      = (SKIP_X0 != 0) && (RegNum == 5'd0);
    assign w_reg_hit = cfg_reg_en & RegWriteSignal & ~w_x0;
    assign w_wr_hit  = cfg_mem_en & WriteEnable & ~ReadEnable;
    assign w_rd_hit  = cfg_mem_en & ReadEnable & ~WriteEnable;
    assign w_mem_hit = w_wr_hit | w_rd_hit;
    assign w_push    = w_reg_hit | w_mem_hit;

    assign trace_valid = (r_level != '0);
    assign w_pop       = trace_valid & trace_ready;
    // A full FIFO still takes the new record when the head leaves on the same edge.
    assign w_accept    = w_push & ((r_level != LVL_FULL) | w_pop);

    assign w_rec = {w_reg_hit, w_wr_hit, w_rd_hit,
                    w_reg_hit ? RegNum  : 5'd0,
                    w_reg_hit ? RegData : 32'd0,
                    w_mem_hit ? Address : {ADDR_W{1'b0}},
                    w_wr_hit  ? WRData  : (w_rd_hit ? RDData : 32'd0),
                    r_ts};

    // Storage is left unreset; outputs are masked while empty instead.
    assign w_head = trace_valid ? r_mem[r_rd_ptr] : '0;
    assign {trace_kind, trace_reg_num, trace_reg_data,
            trace_mem_addr, trace_mem_data, trace_ts} = w_head;

    assign level      = r_level;
    assign drop_count = r_drop;
    assign conflict   = r_conflict;

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= w_rec;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ts       <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_drop     <= '0;
            r_conflict <= 1'b0;
        end else begin
            r_ts <= r_ts + 1'b1;
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_accept, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            if (w_push && !w_accept && (r_drop != 16'hFFFF)) begin
                r_drop <= r_drop + 1'b1;
            end
            if (WriteEnable && ReadEnable) begin
                r_conflict <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_riscv_trace_buffer.sv
// Directed and scoreboard-checked bench for riscv_trace_buffer.
module tb_riscv_trace_buffer;
    localparam int DEPTH = 16;

    typedef struct packed {
        logic [2:0]  k;
        logic [4:0]  rn;
        logic [31:0] rd;
        logic [8:0]  a;
        logic [31:0] md;
        logic [15:0] ts;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_reg_en, cfg_mem_en;
    logic        RegWriteSignal;
    logic [4:0]  RegNum;
    logic [31:0] RegData;
    logic        WriteEnable, ReadEnable;
    logic [8:0]  Address;
    logic [31:0] WRData, RDData;
    logic        trace_valid, trace_ready;
    logic [2:0]  trace_kind;
    logic [4:0]  trace_reg_num;
    logic [31:0] trace_reg_data;
    logic [8:0]  trace_mem_addr;
    logic [31:0] trace_mem_data;
    logic [15:0] trace_ts;
    logic [4:0]  level;
    logic [15:0] drop_count;
    logic        conflict;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] cyc;
    rec_t q[$];
    rec_t head;

    riscv_trace_buffer #(.DEPTH(DEPTH), .ADDR_W(9), .TS_W(16), .SKIP_X0(1)) dut (
        .clk(clk), .rst(rst), .cfg_reg_en(cfg_reg_en), .cfg_mem_en(cfg_mem_en),
        .RegWriteSignal(RegWriteSignal), .RegNum(RegNum), .RegData(RegData),
        .WriteEnable(WriteEnable), .ReadEnable(ReadEnable), .Address(Address),
        .WRData(WRData), .RDData(RDData), .trace_valid(trace_valid),
        .trace_ready(trace_ready), .trace_kind(trace_kind), .trace_reg_num(trace_reg_num),
        .trace_reg_data(trace_reg_data), .trace_mem_addr(trace_mem_addr),
        .trace_mem_data(trace_mem_data), .trace_ts(trace_ts), .level(level),
        .drop_count(drop_count), .conflict(conflict)
    );

    always #5 clk = ~clk;

    // Bench-side timestamp: number of edges since reset release.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= '0;
        else     cyc <= cyc + 16'd1;
    end

    assign head = {trace_kind, trace_reg_num, trace_reg_data, trace_mem_addr, trace_mem_data, trace_ts};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        RegWriteSignal = 1'b0; RegNum = '0; RegData = '0;
        WriteEnable = 1'b0; ReadEnable = 1'b0; Address = '0;
        WRData = '0; RDData = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        cfg_reg_en = 1'b1; cfg_mem_en = 1'b1; trace_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        cfg_reg_en = 1'b1; cfg_mem_en = 1'b1; trace_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({trace_valid, level, drop_count, conflict} !== {1'b0, 5'd0, 16'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_status: got v=%0b lvl=%0d drop=%0d cf=%0b, want 0/0/0/0",
                     trace_valid, level, drop_count, conflict);
        end
        n_tests++;
        if (head !== rec_t'(0)) begin
            n_fail++;
            $display("FAIL reset_head: got %h, want 0", head);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_event();
        do_reset();
        repeat (3) step();
        RegWriteSignal = 1'b1; RegNum = 5'd5; RegData = 32'h2A;
        step();
        idle_inputs();
        n_tests++;
        if ({trace_valid, level} !== {1'b1, 5'd1}) begin
            n_fail++;
            $display("FAIL single_valid: got v=%0b lvl=%0d, want v=1 lvl=1", trace_valid, level);
        end
        n_tests++;
        if ({trace_kind, trace_reg_num, trace_reg_data, trace_ts} !== {3'b100, 5'd5, 32'h2A, 16'd3}) begin
            n_fail++;
            $display("FAIL single_fields: got k=%b rn=%0d rd=%h ts=%0d, want k=100 rn=5 rd=2a ts=3",
                     trace_kind, trace_reg_num, trace_reg_data, trace_ts);
        end
        n_tests++;
        if ({trace_mem_addr, trace_mem_data} !== {9'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL single_mem_zero: got a=%h md=%h, want 0/0", trace_mem_addr, trace_mem_data);
        end
        trace_ready = 1'b1;
        step();
        trace_ready = 1'b0;
        n_tests++;
        if ({trace_valid, level} !== {1'b0, 5'd0}) begin
            n_fail++;
            $display("FAIL single_drain: got v=%0b lvl=%0d, want 0/0", trace_valid, level);
        end
        // Empty FIFO with ready high must not underflow.
        trace_ready = 1'b1;
        step(); step();
        trace_ready = 1'b0;
        n_tests++;
        if (level !== 5'd0) begin
            n_fail++;
            $display("FAIL empty_ready: got lvl=%0d, want 0", level);
        end
    endtask

    task automatic test_filter();
        do_reset();
        cfg_mem_en = 1'b0;
        RegWriteSignal = 1'b1; RegNum = 5'd0; RegData = 32'h55;
        step();
        idle_inputs();
        WriteEnable = 1'b1; Address = 9'd16; WRData = 32'hDEADBEEF;
        step();
        idle_inputs();
        step();
        n_tests++;
        if ({trace_valid, level} !== {1'b0, 5'd0}) begin
            n_fail++;
            $display("FAIL filter_none: got v=%0b lvl=%0d, want 0/0", trace_valid, level);
        end
        cfg_mem_en = 1'b1;
        WriteEnable = 1'b1; Address = 9'd16; WRData = 32'hDEADBEEF; RDData = 32'h1234;
        step();
        idle_inputs();
        step();
        n_tests++;
        if ({level, trace_kind, trace_reg_num, trace_reg_data, trace_mem_addr, trace_mem_data}
            !== {5'd1, 3'b010, 5'd0, 32'd0, 9'd16, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL filter_memwr: got lvl=%0d k=%b rn=%0d rd=%h a=%0d md=%h, want 1 010 0 0 16 deadbeef",
                     level, trace_kind, trace_reg_num, trace_reg_data, trace_mem_addr, trace_mem_data);
        end
    endtask

    task automatic test_combined_conflict();
        do_reset();
        RegWriteSignal = 1'b1; RegNum = 5'd7; RegData = 32'h11;
        ReadEnable = 1'b1; Address = 9'd3; RDData = 32'h7; WRData = 32'hFFFF;
        step();
        idle_inputs();
        n_tests++;
        if ({level, trace_kind, trace_reg_num, trace_reg_data, trace_mem_addr, trace_mem_data, conflict}
            !== {5'd1, 3'b101, 5'd7, 32'h11, 9'd3, 32'h7, 1'b0}) begin
            n_fail++;
            $display("FAIL combined: got lvl=%0d k=%b rn=%0d rd=%h a=%0d md=%h cf=%0b, want 1 101 7 11 3 7 0",
                     level, trace_kind, trace_reg_num, trace_reg_data, trace_mem_addr, trace_mem_data, conflict);
        end
        trace_ready = 1'b1;
        step();
        trace_ready = 1'b0;
        cfg_mem_en = 1'b0;
        WriteEnable = 1'b1; ReadEnable = 1'b1; Address = 9'd9;
        step();
        idle_inputs();
        n_tests++;
        if ({conflict, level} !== {1'b1, 5'd0}) begin
            n_fail++;
            $display("FAIL conflict_set: got cf=%0b lvl=%0d, want 1/0", conflict, level);
        end
        cfg_mem_en = 1'b1;
        repeat (4) step();
        n_tests++;
        if (conflict !== 1'b1) begin
            n_fail++;
            $display("FAIL conflict_sticky: got %0b, want 1", conflict);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < DEPTH + 3; i++) begin
            RegWriteSignal = 1'b1; RegNum = 5'(i % 31 + 1); RegData = 32'(i + 100);
            step();
        end
        idle_inputs();
        n_tests++;
        if ({level, drop_count, trace_reg_num, trace_reg_data} !== {5'd16, 16'd3, 5'd1, 32'd100}) begin
            n_fail++;
            $display("FAIL overflow: got lvl=%0d drop=%0d rn=%0d rd=%0d, want 16 3 1 100",
                     level, drop_count, trace_reg_num, trace_reg_data);
        end
        trace_ready = 1'b1;
        RegWriteSignal = 1'b1; RegNum = 5'd9; RegData = 32'd999;
        step();
        idle_inputs();
        trace_ready = 1'b0;
        n_tests++;
        if ({level, drop_count, trace_reg_data} !== {5'd16, 16'd3, 32'd101}) begin
            n_fail++;
            $display("FAIL full_push_pop: got lvl=%0d drop=%0d rd=%0d, want 16 3 101",
                     level, drop_count, trace_reg_data);
        end
    endtask

    task automatic test_back_to_back();
        int   drops = 0;
        bit   stalled = 0;
        bit   rdy, pop, accept, rg;
        int   m;
        rec_t held = '0;
        rec_t e;
        do_reset();
        q.delete();
        for (int i = 0; i < 200; i++) begin
            n_tests++;
            if (trace_valid !== (q.size() != 0)) begin
                n_fail++;
                $display("FAIL bp_valid[%0d]: got %0b, want %0b", i, trace_valid, q.size() != 0);
            end
            if (q.size() != 0) begin
                n_tests++;
                if (head !== q[0]) begin
                    n_fail++;
                    $display("FAIL bp_head[%0d]: got %h, want %h", i, head, q[0]);
                end
            end
            if (stalled) begin
                n_tests++;
                if (head !== held) begin
                    n_fail++;
                    $display("FAIL bp_stable[%0d]: got %h, want %h", i, head, held);
                end
            end
            rdy     = 1'($urandom_range(0, 1));
            stalled = (q.size() != 0) && !rdy;
            held    = head;
            pop     = (q.size() != 0) && rdy;
            rg = 1'($urandom_range(0, 1));
            m  = $urandom_range(0, 2);
            if (!rg && m == 0) rg = 1'b1;
            RegWriteSignal = rg; RegNum = 5'($urandom_range(1, 31)); RegData = $urandom;
            WriteEnable = (m == 1); ReadEnable = (m == 2);
            Address = 9'($urandom); WRData = $urandom; RDData = $urandom;
            e.k  = {rg, m == 1, m == 2};
            e.rn = rg ? RegNum : 5'd0;
            e.rd = rg ? RegData : 32'd0;
            e.a  = (m != 0) ? Address : 9'd0;
            e.md = (m == 1) ? WRData : ((m == 2) ? RDData : 32'd0);
            e.ts = cyc;
            accept = (q.size() < DEPTH) || pop;
            if (pop) void'(q.pop_front());
            if (accept) q.push_back(e);
            else drops++;
            trace_ready = rdy;
            step();
        end
        idle_inputs();
        trace_ready = 1'b1;
        for (int i = 0; i < 3 * DEPTH && q.size() != 0; i++) begin
            n_tests++;
            if (!trace_valid || head !== q[0]) begin
                n_fail++;
                $display("FAIL bp_drain[%0d]: got v=%0b %h, want %h", i, trace_valid, head, q[0]);
            end
            void'(q.pop_front());
            step();
        end
        trace_ready = 1'b0;
        n_tests++;
        if ({level, drop_count} !== {5'd0, 16'(drops)} || q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_end: got lvl=%0d drop=%0d left=%0d, want 0 %0d 0",
                     level, drop_count, q.size(), drops);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            RegWriteSignal = 1'b1; RegNum = 5'd4; RegData = 32'(i);
            step();
        end
        n_tests++;
        if (level !== 5'd5) begin
            n_fail++;
            $display("FAIL async_pre: got lvl=%0d, want 5", level);
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({trace_valid, level} !== {1'b0, 5'd0}) begin
            n_fail++;
            $display("FAIL async_now: got v=%0b lvl=%0d, want 0/0", trace_valid, level);
        end
        idle_inputs();
        @(posedge clk);
        #1 rst = 1'b0;
        RegWriteSignal = 1'b1; RegNum = 5'd8; RegData = 32'hABCD;
        step();
        idle_inputs();
        n_tests++;
        if ({trace_valid, level, trace_reg_data, trace_ts} !== {1'b1, 5'd1, 32'hABCD, 16'd0}) begin
            n_fail++;
            $display("FAIL async_restart: got v=%0b lvl=%0d rd=%h ts=%0d, want 1 1 abcd 0",
                     trace_valid, level, trace_reg_data, trace_ts);
        end
    endtask

    initial begin
        test_reset();
        test_single_event();
        test_filter();
        test_combined_conflict();
        test_overflow();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
